pixel_readout_ctrl: RTL and testbench
=====================================

// Module: pixel_readout_ctrl
// PURPOSE
// - Controller at the other end of the 4-pixel sensor array interface.
// - Drives erase/expose/ramp/read strobes and the shared 8-bit pixel bus during ADC conversion.
// - Reads back the four latched pixel codes and streams them out over a valid/ready handshake.
// - Sits between the pixel array and the frame buffer, one frame per start pulse.
// PARAMETERS
// C_ERASE   5    cycles erase held high (1..65535)
// C_EXPOSE  255  cycles expose held high (1..65535)
// C_SETTLE  2    cycles read[i] held high before pixel bus is sampled (1..255)
// PORTS
// clk          in   1  system clock, all logic on rising edge
// reset        in   1  asynchronous, active-high reset
// start        in   1  pulse; begins a frame when idle, ignored when busy
// busy         out  1  high in any state other than IDLE
// erase        out  1  pixel erase strobe
// expose       out  1  pixel expose strobe
// convert      out  1  ADC ramp enable (anaRamp gate)
// read         out  4  one-hot pixel read select, read[0] = pixel 1
// pix_out      out  8  ADC counter value driven onto pixel bus
// pix_oe       out  1  pixel bus output enable (top level tri-states pix_out)
// pix_in       in   8  pixel bus sampled value
// out_data     out  8  pixel code
// out_idx      out  2  pixel index of out_data
// out_last     out  1  high with out_valid when out_idx == 3
// out_valid    out  1  out_data valid
// out_ready    in   1  sink accepts when out_valid && out_ready at clk edge
// BEHAVIOUR
// - Reset (async, any time): state=IDLE.
//   - Outputs all 0: busy, erase, expose, convert, read, pix_out, pix_oe, out_*.
//   - Pending frame abandoned, no partial output.
// - States: IDLE -> ERASE -> EXPOSE -> CONVERT -> GAP -> READ_SETTLE -> READ_WAIT -> (READ_SETTLE | IDLE).
// - IDLE: on start=1, next cycle ERASE.
// - ERASE: erase=1 exactly C_ERASE cycles, then EXPOSE.
// - EXPOSE: expose=1 exactly C_EXPOSE cycles, then CONVERT.
// - CONVERT: exactly 256 cycles with convert=1 and pix_oe=1.
//   - pix_out = 0,1,..,255 in consecutive cycles, 8-bit, no wrap.
//   - After the cycle with pix_out=255 -> GAP.
// - GAP: 1 cycle, all strobes 0, pix_oe=0 (bus turnaround). Pixel index i=0.
// - READ_SETTLE: read = 1<<i for C_SETTLE cycles, pix_oe=0.
//   - On the last settle cycle pix_in is registered into out_data; out_idx=i.
//   - Next cycle read=0 and out_valid=1 -> READ_WAIT.
// - READ_WAIT: out_valid, out_data, out_idx, out_last held stable until accepted.
//   - On accept (out_valid && out_ready): out_valid=0 next cycle.
//   - If i<3: i+1, go READ_SETTLE.
//   - If i==3: go IDLE.
// - out_ready high while out_valid=0 has no effect. Pixels are never dropped or reordered.
// - start while busy: ignored, not queued.
// - Start and accept on the same edge in READ_WAIT (i==3): IDLE entered, start ignored.
// - read is never non-zero while pix_oe=1. erase/expose/convert/read are mutually exclusive.
// - Strobe outputs and pix_out are registered (no combinational path from inputs).
// - Latency, start to first out_valid: 1+C_ERASE+C_EXPOSE+256+1+C_SETTLE+1 cycles.
// - Phase timers are 16-bit.
// CONFIGURATION
// - PIXEL_FRAME_CNT_EN defined:
//   - Extra port frame_cnt out 16: count of fully delivered frames (last pixel accepted).
//   - Reset to 0, wraps 65535 -> 0.
//   - Aborted frames (reset) are not counted; the count itself is cleared by reset.
// - PIXEL_FRAME_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// 1. Reset mid-CONVERT (pix_out=100), reset=1 -> same instant pix_oe=0, convert=0, busy=0; frame restarts only on next start.
// 2. C_ERASE=5, C_EXPOSE=10, C_SETTLE=2, start pulse -> erase high 5 cycles, expose 10, convert 256.
//    pix_out ramps 0..255, first out_valid at cycle 1+5+10+256+1+2+1=276 after start.
// 3. Pixel model latches codes 17,200,0,255, out_ready=1 -> out_data 17,200,0,255, out_idx 0..3, out_last only with 255.
// 4. out_ready=0 for 20 cycles on pixel 1 -> out_valid and out_data=200 stable for 20 cycles, read=0; resumes after ready.
// 5. start during EXPOSE, then a frame with start pulsed in the accept cycle of pixel 3 -> no extra frame; busy=0 after.
// 6. PIXEL_FRAME_CNT_EN defined, 3 full frames plus 1 aborted by reset -> frame_cnt=3 before the reset, 0 after it.

Source files
------------

// File: rtl/pixel_readout_ctrl.sv
// Pixel array readout controller: erase/expose/ramp sequencing and pixel streaming.
// Optional completed-frame counter enabled by defining PIXEL_FRAME_CNT_EN.
module pixel_readout_ctrl #(
   parameter int C_ERASE  = 5,
   parameter int C_EXPOSE = 255,
   parameter int C_SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       erase,
   output logic       expose,
   output logic       convert,
   output logic [3:0] read,
   output logic [7:0] pix_out,
   output logic       pix_oe,
   input  logic [7:0] pix_in,
   output logic [7:0] out_data,
   output logic [1:0] out_idx,
   output logic       out_last,
   output logic       out_valid,
   input  logic       out_ready
`ifdef PIXEL_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ERASE   = 3'd1;
   localparam logic [2:0] S_EXPOSE  = 3'd2;
   localparam logic [2:0] S_CONVERT = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;
   localparam logic [2:0] S_SETTLE  = 3'd5;
   localparam logic [2:0] S_WAIT    = 3'd6;

   // Timers count down from (length - 1) so the phase ends on zero.
   localparam logic [15:0] ERASE_LOAD  = 16'(C_ERASE - 1);
   localparam logic [15:0] EXPOSE_LOAD = 16'(C_EXPOSE - 1);
   localparam logic [15:0] SETTLE_LOAD = 16'(C_SETTLE - 1);

   logic [2:0]  state;
   logic [15:0] timer;
   logic [1:0]  pixIdx;
   logic [1:0]  nextIdx;
   logic        timerDone;
   logic        accept;

   assign nextIdx   = pixIdx + 2'd1;
   assign timerDone = (timer == 16'd0);
   assign accept    = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         timer     <= '0;
         pixIdx    <= '0;
         busy      <= 1'b0;
         erase     <= 1'b0;
         expose    <= 1'b0;
         convert   <= 1'b0;
         read      <= '0;
         pix_out   <= '0;
         pix_oe    <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ERASE;
                  busy  <= 1'b1;
                  erase <= 1'b1;
                  timer <= ERASE_LOAD;
               end
            end
            S_ERASE: begin
               if (timerDone) begin
                  state  <= S_EXPOSE;
                  erase  <= 1'b0;
                  expose <= 1'b1;
                  timer  <= EXPOSE_LOAD;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            S_EXPOSE: begin
               if (timerDone) begin
                  state   <= S_CONVERT;
                  expose  <= 1'b0;
                  convert <= 1'b1;
                  pix_oe  <= 1'b1;
                  pix_out <= 8'd0;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            S_CONVERT: begin
               // The ramp value itself marks the end of conversion.
               if (pix_out == 8'hFF) begin
                  state   <= S_GAP;
                  convert <= 1'b0;
                  pix_oe  <= 1'b0;
                  pix_out <= 8'd0;
                  pixIdx  <= 2'd0;
               end else begin
                  pix_out <= pix_out + 8'd1;
               end
            end
            S_GAP: begin
               state <= S_SETTLE;
               read  <= 4'b0001;
               timer <= SETTLE_LOAD;
            end
            S_SETTLE: begin
               if (timerDone) begin
                  state     <= S_WAIT;
                  read      <= 4'b0000;
                  out_data  <= pix_in;
                  out_idx   <= pixIdx;
                  out_last  <= (pixIdx == 2'd3);
                  out_valid <= 1'b1;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            S_WAIT: begin
               if (accept) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (pixIdx == 2'd3) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state  <= S_SETTLE;
                     pixIdx <= nextIdx;
                     read   <= 4'b0001 << nextIdx;
                     timer  <= SETTLE_LOAD;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               erase     <= 1'b0;
               expose    <= 1'b0;
               convert   <= 1'b0;
               read      <= '0;
               pix_oe    <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIXEL_FRAME_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (state == S_WAIT && accept && pixIdx == 2'd3) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Scoreboard bench for pixel_readout_ctrl (C_ERASE=5, C_EXPOSE=10, C_SETTLE=2).
module tb_pixel_readout_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy, erase, expose, convert, pix_oe;
   logic [3:0] read;
   logic [7:0] pix_out, pix_in, out_data;
   logic [1:0] out_idx;
   logic       out_last, out_valid, out_ready;
`ifdef PIXEL_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int expFrames = 0;
   logic [7:0]  codes [4];
   logic [10:0] expQ [$];

   always #5 clk = ~clk;

   pixel_readout_ctrl #(.C_ERASE(5), .C_EXPOSE(10), .C_SETTLE(2)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .erase(erase), .expose(expose), .convert(convert), .read(read),
      .pix_out(pix_out), .pix_oe(pix_oe), .pix_in(pix_in),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIXEL_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   // Pixel array model: selected pixel drives its latched code.
   always_comb begin
      pix_in = 8'h00;
      if (read[0]) pix_in = codes[0];
      if (read[1]) pix_in = codes[1];
      if (read[2]) pix_in = codes[2];
      if (read[3]) pix_in = codes[3];
   end

   always @(negedge clk) begin
      logic [10:0] e;
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got idx=%0d data=%0d want none", out_idx, out_data);
         end else begin
            e = expQ.pop_front();
            if ({out_last, out_idx, out_data} !== e) begin
               failures++;
               $display("FAIL sb_pixel got last=%0d idx=%0d data=%0d want last=%0d idx=%0d data=%0d",
                        out_last, out_idx, out_data, e[10], e[9:8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ((pix_oe && read != 4'd0) || !$onehot0(read) ||
             $countones({erase, expose, convert, |read}) > 1) begin
            failures++;
            $display("FAIL strobe_excl got e=%0d x=%0d c=%0d rd=%b oe=%0d want exclusive",
                     erase, expose, convert, read, pix_oe);
         end
      end
   end

   task automatic begin_frame(input logic [7:0] c0, c1, c2, c3);
      codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
      expQ.push_back({1'b0, 2'd0, c0});
      expQ.push_back({1'b0, 2'd1, c1});
      expQ.push_back({1'b0, 2'd2, c2});
      expQ.push_back({1'b1, 2'd3, c3});
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      codes[0] = 0; codes[1] = 0; codes[2] = 0; codes[3] = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, erase, expose, convert, read, pix_out, pix_oe,
           out_data, out_idx, out_last, out_valid} !== 28'd0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%0d valid=%0d pix_out=%0d want all 0",
                  busy, out_valid, pix_out);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_timing;
      int cyc, ecnt, xcnt, ccnt, rampExp, rampErr, firstValid;
      ecnt = 0; xcnt = 0; ccnt = 0; rampExp = 0; rampErr = 0; firstValid = 0;
      out_ready = 1'b1;
      begin_frame(8'd17, 8'd200, 8'd0, 8'd255);
      cyc = 2;
      for (int k = 0; k < 400; k++) begin
         if (erase) ecnt++;
         if (expose) xcnt++;
         if (convert) begin
            ccnt++;
            if (pix_out !== 8'(rampExp) || !pix_oe) rampErr++;
            rampExp++;
         end
         if (out_valid && firstValid == 0) firstValid = cyc;
         if (!busy) break;
         @(posedge clk); #1;
         cyc++;
      end
      expFrames++;
      checks++;
      if (ecnt != 5) begin failures++; $display("FAIL erase_len got %0d want 5", ecnt); end
      checks++;
      if (xcnt != 10) begin failures++; $display("FAIL expose_len got %0d want 10", xcnt); end
      checks++;
      if (ccnt != 256) begin failures++; $display("FAIL convert_len got %0d want 256", ccnt); end
      checks++;
      if (rampErr != 0) begin failures++; $display("FAIL ramp got %0d errors want 0", rampErr); end
      checks++;
      if (firstValid != 276) begin
         failures++; $display("FAIL first_valid got %0d want 276", firstValid);
      end
      checks++;
      if (busy !== 1'b0 || expQ.size() != 0) begin
         failures++; $display("FAIL frame1_end got busy=%0d q=%0d want 0 0", busy, expQ.size());
      end
   endtask

   task automatic test_backpressure;
      int holdErr;
      holdErr = 0;
      out_ready = 1'b1;
      begin_frame(8'd5, 8'd200, 8'd9, 8'd77);
      for (int k = 0; k < 400 && !(out_valid && out_idx == 2'd1); k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (!(out_valid && out_idx == 2'd1)) begin
         failures++; $display("FAIL bp_timeout got valid=%0d want 1", out_valid);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_data !== 8'd200 || read !== 4'd0 ||
             out_idx !== 2'd1) holdErr++;
      end
      checks++;
      if (holdErr != 0) begin
         failures++; $display("FAIL bp_hold got %0d errors want 0", holdErr);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 100 && busy; k++) begin
         @(posedge clk); #1;
      end
      expFrames++;
      checks++;
      if (busy !== 1'b0 || expQ.size() != 0) begin
         failures++; $display("FAIL bp_end got busy=%0d q=%0d want 0 0", busy, expQ.size());
      end
   endtask

   task automatic test_start_ignored;
      int busyErr;
      out_ready = 1'b1;
      begin_frame(8'd1, 8'd2, 8'd3, 8'd4);
      for (int k = 0; k < 50 && !expose; k++) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 400 && busy; k++) begin
         @(posedge clk); #1;
      end
      expFrames++;
      busyErr = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (busy) busyErr++;
      end
      checks++;
      if (busyErr != 0) begin
         failures++; $display("FAIL start_queued got %0d busy cycles want 0", busyErr);
      end
      begin_frame(8'd90, 8'd91, 8'd92, 8'd93);
      for (int k = 0; k < 400 && !(out_valid && out_idx == 2'd3); k++) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      expFrames++;
      busyErr = 0;
      for (int k = 0; k < 10; k++) begin
         if (busy || erase) busyErr++;
         @(posedge clk); #1;
      end
      checks++;
      if (busyErr != 0 || expQ.size() != 0) begin
         failures++;
         $display("FAIL start_on_accept got %0d busy cycles q=%0d want 0 0", busyErr, expQ.size());
      end
   endtask

   task automatic test_reset_mid_convert;
      out_ready = 1'b0;
      codes[0] = 8'd7; codes[1] = 8'd8; codes[2] = 8'd9; codes[3] = 8'd10;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 200 && !(convert && pix_out == 8'd100); k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (!(convert && pix_out == 8'd100)) begin
         failures++; $display("FAIL rst_reach got pix_out=%0d want 100", pix_out);
      end
`ifdef PIXEL_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 16'(expFrames)) begin
         failures++; $display("FAIL frame_cnt got %0d want %0d", frame_cnt, expFrames);
      end
`endif
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pix_oe !== 1'b0 || convert !== 1'b0 || busy !== 1'b0 || pix_out !== 8'd0) begin
         failures++;
         $display("FAIL rst_async got oe=%0d conv=%0d busy=%0d pix=%0d want 0",
                  pix_oe, convert, busy, pix_out);
      end
`ifdef PIXEL_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 16'd0) begin
         failures++; $display("FAIL frame_cnt_rst got %0d want 0", frame_cnt);
      end
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL rst_restart got busy=%0d valid=%0d want 0", busy, out_valid);
      end
      out_ready = 1'b1;
      begin_frame(8'd33, 8'd44, 8'd55, 8'd66);
      for (int k = 0; k < 400 && busy; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (busy !== 1'b0 || expQ.size() != 0) begin
         failures++; $display("FAIL post_rst_frame got busy=%0d q=%0d want 0 0", busy, expQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_convert();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
